// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Types and constants shared by the UART transmitter and receiver.
//            Holds the frame-state enum, the parity-mode codes, the default
//            bit period and a small parity helper.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Frame states, in the order they occur on the line.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity mode codes.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // 9600 Bd at 100 MHz.
  localparam logic [13:0] KBAUD_DEFAULT = 14'd10416;

  // Parity bit for a data byte: even parity is the XOR of the data bits,
  // odd parity is its inverse.
  function automatic logic parity_bit(input logic [7:0] d, input int mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Bit-period timer. Pulses tick in the last cycle of every
//            KBAUD-cycle bit period; clear holds the count at zero so the
//            first period starts cleanly on the cycle clear drops.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            clear - synchronous counter clear (held while the line is idle)
//            tick  - one-cycle pulse at each bit boundary
// Revision : 1.0  initial release
// ============================================================================
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter logic [13:0] KBAUD = KBAUD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(KBAUD);
  localparam logic [CW-1:0] LAST = CW'(KBAUD - 14'd1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8-bit UART transmitter. Start bit, 8 data bits LSB first,
//            optional parity bit, 1 or 2 stop bits; each bit KBAUD cycles.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            data_IN  - byte to send, sampled in the accept cycle
//            Tx_start - level-sensitive transmit request
//            data_OUT - registered serial line, idles high
//            busy     - high while a frame is in progress
//            Tx_done  - one-cycle pulse in the first idle cycle after a frame
// Revision : 1.0  initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter logic [13:0] KBAUD     = KBAUD_DEFAULT,
  parameter int          PARITY    = PAR_NONE,
  parameter int          STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_IN,
  input  logic       Tx_start,
  output logic       data_OUT,
  output logic       busy,
  output logic       Tx_done
);

  localparam logic LAST_STOP = (STOP_BITS == 2);

  state_t     state, state_nx;
  logic [7:0] byte_q;
  logic [2:0] bit_idx, bit_idx_nx;
  logic       stop_idx, stop_idx_nx;
  logic       tx_q, tx_nx;
  logic       done_q, done_nx;
  logic       tick;
  logic       accept;
  logic       baud_clear;
  logic       par_bit;

  assign accept     = (state == ST_IDLE) && Tx_start;
  assign baud_clear = (state == ST_IDLE);
  assign par_bit    = parity_bit(byte_q, PARITY);

  uart_baud_gen #(
    .KBAUD (KBAUD)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      byte_q   <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_idx  <= bit_idx_nx;
      stop_idx <= stop_idx_nx;
      tx_q     <= tx_nx;
      done_q   <= done_nx;
      if (accept) begin
        byte_q <= data_IN;
      end
    end
  end

  // The line value is computed for the *next* state and registered, so the
  // registered line always lines up with the registered state.
  always_comb begin
    state_nx    = state;
    bit_idx_nx  = bit_idx;
    stop_idx_nx = stop_idx;
    tx_nx       = 1'b1;
    done_nx     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Tx_start) begin
          state_nx    = ST_START;
          bit_idx_nx  = 3'd0;
          stop_idx_nx = 1'b0;
          tx_nx       = 1'b0;
        end
      end
      ST_START: begin
        tx_nx = 1'b0;
        if (tick) begin
          state_nx = ST_DATA;
          tx_nx    = byte_q[0];
        end
      end
      ST_DATA: begin
        tx_nx = byte_q[bit_idx];
        if (tick) begin
          if (bit_idx == 3'd7) begin
            if (PARITY != PAR_NONE) begin
              state_nx = ST_PARITY;
              tx_nx    = par_bit;
            end else begin
              state_nx = ST_STOP;
              tx_nx    = 1'b1;
            end
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            tx_nx      = byte_q[bit_idx + 3'd1];
          end
        end
      end
      ST_PARITY: begin
        tx_nx = par_bit;
        if (tick) begin
          state_nx = ST_STOP;
          tx_nx    = 1'b1;
        end
      end
      ST_STOP: begin
        tx_nx = 1'b1;
        if (tick) begin
          if (stop_idx == LAST_STOP) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
          end else begin
            stop_idx_nx = 1'b1;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign data_OUT = tx_q;
  assign busy     = (state != ST_IDLE);
  assign Tx_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. Three instances at KBAUD=16
//            cover no parity / 1 stop, even parity / 2 stops and odd
//            parity / 1 stop. Expected frames come from a bit-list model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

  localparam int KB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic [2:0] start_v;
  wire  [2:0] line_v;
  wire  [2:0] busy_v;
  wire  [2:0] done_v;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx #(.KBAUD(14'd16), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_IN(data_in), .Tx_start(start_v[0]),
    .data_OUT(line_v[0]), .busy(busy_v[0]), .Tx_done(done_v[0]));

  uart_tx #(.KBAUD(14'd16), .PARITY(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_IN(data_in), .Tx_start(start_v[1]),
    .data_OUT(line_v[1]), .busy(busy_v[1]), .Tx_done(done_v[1]));

  uart_tx #(.KBAUD(14'd16), .PARITY(2), .STOP_BITS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .data_IN(data_in), .Tx_start(start_v[2]),
    .data_OUT(line_v[2]), .busy(busy_v[2]), .Tx_done(done_v[2]));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int par_of(input int w);
    return (w == 0) ? 0 : (w == 1) ? 1 : 2;
  endfunction

  function automatic int stops_of(input int w);
    return (w == 1) ? 2 : 1;
  endfunction

  // Frame as a list of line levels, one entry per bit period.
  function automatic void model(input logic [7:0] b, input int par, input int stops,
                                output logic [11:0] bits, output int n);
    int ones;
    bits = '1;
    n    = 0;
    ones = 0;
    bits[n] = 1'b0; n++;
    for (int k = 0; k < 8; k++) begin
      bits[n] = b[k]; n++;
      ones += b[k];
    end
    if (par == 1) begin bits[n] = ((ones % 2) == 1); n++; end
    if (par == 2) begin bits[n] = ((ones % 2) == 0); n++; end
    for (int k = 0; k < stops; k++) begin bits[n] = 1'b1; n++; end
  endfunction

  // Called on a falling edge where the target is idle (or in its Tx_done
  // cycle); returns on the falling edge of the expected Tx_done cycle.
  task automatic send_frame(input int w, input logic [7:0] b, input bit hold,
                            input logic [7:0] other, input int glitch_at);
    logic [11:0] bits;
    int n, total, busy_cnt, done_cnt;
    int match[12];
    model(b, par_of(w), stops_of(w), bits, n);
    total = n * KB;
    data_in    = b;
    start_v[w] = 1'b1;
    @(negedge clk);
    if (!hold) start_v[w] = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) match[k] = 0;
    for (int i = 0; i < total; i++) begin
      if (line_v[w] == bits[i / KB]) match[i / KB]++;
      if (busy_v[w]) busy_cnt++;
      if (done_v[w]) done_cnt++;
      if (hold && i == 0) data_in = other;
      if (i == glitch_at) begin
        start_v[w] = 1'b1;
        data_in    = other;
      end else if (glitch_at >= 0 && i == glitch_at + 1) begin
        start_v[w] = 1'b0;
      end
      @(negedge clk);
    end
    for (int k = 0; k < n; k++) check($sformatf("bit%0d_b%02h_u%0d", k, b, w), match[k], KB);
    check($sformatf("busy_len_u%0d", w), busy_cnt, total);
    check($sformatf("early_done_u%0d", w), done_cnt, 0);
    check($sformatf("done_pulse_u%0d", w), int'(done_v[w]), 1);
    check($sformatf("idle_line_u%0d", w), int'(line_v[w]), 1);
    check($sformatf("idle_busy_u%0d", w), int'(busy_v[w]), 0);
  endtask

  // Target must stay idle (no frame, no Tx_done) for the given cycles.
  task automatic quiet(input int w, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy_v[w] || done_v[w] || !line_v[w]) bad++;
    end
    check($sformatf("quiet_u%0d", w), bad, 0);
  endtask

  initial begin
    int gap, w;
    logic [7:0] b;
    rst_n   = 1'b1;
    data_in = '0;
    start_v = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_line", int'(line_v), 7);
    check("rst_busy", int'(busy_v), 0);
    check("rst_done", int'(done_v), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frames, parity cases and two stop bits.
    send_frame(0, 8'hA5, 1'b0, 8'h00, -1);
    quiet(0, 2);
    send_frame(1, 8'h07, 1'b0, 8'h00, -1);
    quiet(1, 2);
    send_frame(2, 8'h00, 1'b0, 8'h00, -1);
    quiet(2, 2);

    // Request during a frame is ignored.
    send_frame(0, 8'h5A, 1'b0, 8'h3C, 40);
    quiet(0, 5);

    // Request held high: two frames separated by one idle cycle.
    send_frame(0, 8'h01, 1'b1, 8'h80, -1);
    send_frame(0, 8'h80, 1'b0, 8'h00, -1);
    quiet(0, 2);

    // Asynchronous reset mid-frame.
    data_in    = 8'hC3;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (69) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_line", int'(line_v[0]), 1);
    check("arst_busy", int'(busy_v[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet(0, 3);
    send_frame(0, 8'hFF, 1'b0, 8'h00, -1);

    // Random bytes on random instances with random gaps (gap 0 starts the
    // next frame in the Tx_done cycle).
    for (int r = 0; r < 24; r++) begin
      w = $urandom_range(0, 2);
      b = 8'($urandom);
      send_frame(w, b, 1'b0, 8'h00, -1);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
